sel_sequencer: RTL

Registered, parametrised successor to the datapath's 10-way byte selector. It picks one of `CHANNELS` words of `WIDTH` bits, or a fixed constant slot, and presents it on a registered output. It also has a scan mode: on a single `start` it streams a contiguous channel range, optionally followed by the constant as a terminator, over a valid/ready handshake. It sits between the cipher's word registers and the display/transmit path, which previously had to step the select lines by hand.

---
 rtl/sel_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sel_sequencer.sv
// Registered channel/constant selector with a handshaked scan mode that streams
// a contiguous channel range, optionally terminated by the constant slot.
module sel_sequencer #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      CHANNELS     = 10,
  parameter int unsigned      SEL_W        = 4,
  parameter logic [WIDTH-1:0] CONST_VAL    = WIDTH'(8'hB7),
  parameter bit               INSERT_CONST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] w,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      start,
  input  logic [SEL_W-1:0]          scan_first,
  input  logic [SEL_W-1:0]          scan_last,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          f,
  output logic [SEL_W-1:0]          f_chan,
  output logic                      f_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] TERM = 2'd2;

  localparam logic [SEL_W-1:0] CONST_IDX = SEL_W'(CHANNELS);

  // Channel word, constant slot, or zero for out-of-range indices.
  function automatic logic [WIDTH-1:0] slot(input logic [SEL_W-1:0]          i,
                                            input logic [CHANNELS*WIDTH-1:0] words);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (i == SEL_W'(k)) v = words[k*WIDTH +: WIDTH];
    end
    if (i == CONST_IDX) v = CONST_VAL;
    return v;
  endfunction

  logic [1:0]       state, state_n;
  logic [SEL_W-1:0] last_q, last_n;
  logic [WIDTH-1:0] f_n;
  logic [SEL_W-1:0] f_chan_n;
  logic             f_valid_n, busy_n, done_n, err_n;
  logic             hs, req_ok;

  assign hs     = f_valid & out_ready;
  assign req_ok = (scan_first <= scan_last) && (scan_last < CONST_IDX);

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    last_n    = last_q;
    f_n       = f;
    f_chan_n  = f_chan;
    f_valid_n = f_valid;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        f_n       = slot(sel, w);
        f_chan_n  = sel;
        f_valid_n = 1'b0;
        busy_n    = 1'b0;
        if (start) begin
          if (req_ok) begin
            f_n       = slot(scan_first, w);
            f_chan_n  = scan_first;
            f_valid_n = 1'b1;
            busy_n    = 1'b1;
            last_n    = scan_last;
            state_n   = EMIT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      EMIT: begin
        if (hs) begin
          if (f_chan < last_q) begin
            f_n      = slot(f_chan + SEL_W'(1), w);
            f_chan_n = f_chan + SEL_W'(1);
          end else if (INSERT_CONST) begin
            f_n      = CONST_VAL;
            f_chan_n = CONST_IDX;
            state_n  = TERM;
          end else begin
            f_valid_n = 1'b0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      TERM: begin
        if (hs) begin
          f_valid_n = 1'b0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          state_n   = IDLE;
        end
      end
      default: begin
        f_valid_n = 1'b0;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_q  <= '0;
      f       <= '0;
      f_chan  <= '0;
      f_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      last_q  <= last_n;
      f       <= f_n;
      f_chan  <= f_chan_n;
      f_valid <= f_valid_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule
